decoder_nto2n_scan: RTL and testbench

DECODER_NTO2N_SCAN -- requirements
Module: decoder_nto2n_scan

---
 rtl/decoder_nto2n_scan.sv | 97 +++++++++
 tb/tb_decoder_nto2n_scan.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_scan.sv
// N-to-2**N decoder with registered one-hot, thermometer, blank and
// self-advancing scan modes; Y polarity is selectable at build time.
module decoder_nto2n_scan #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      A,
    output logic [(1<<N)-1:0] Y,
    output logic [N-1:0]      idx,
    output logic              wrap
);
    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    // y_raw is always active-high; polarity is applied only at the pin
    logic [W-1:0]  y_raw;
    logic [CW-1:0] dcnt;
    logic          scan_active;

    logic [N-1:0]  idx_nxt;
    logic [W-1:0]  onehot_a;
    logic [W-1:0]  therm_a;
    logic [W-1:0]  onehot_nxt;

    assign idx_nxt = idx + N'(1);

    always_comb begin
        onehot_a   = '0;
        therm_a    = '0;
        onehot_nxt = '0;
        for (int i = 0; i < W; i++) begin
            onehot_a[i]   = (A == N'(i));
            therm_a[i]    = (N'(i) <= A);
            onehot_nxt[i] = (idx_nxt == N'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_raw       <= '0;
            idx         <= '0;
            wrap        <= 1'b0;
            dcnt        <= '0;
            scan_active <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (mode != MODE_SCAN) begin
                scan_active <= 1'b0;
                dcnt        <= '0;
            end
            case (mode)
                MODE_DIRECT: begin
                    y_raw <= onehot_a;
                    idx   <= A;
                end
                MODE_THERM: begin
                    y_raw <= therm_a;
                    idx   <= A;
                end
                MODE_SCAN: begin
                    if (!scan_active) begin
                        scan_active <= 1'b1;
                        dcnt        <= '0;
                        idx         <= A;
                        y_raw       <= onehot_a;
                    end else if (dcnt != DLAST) begin
                        dcnt <= dcnt + CW'(1);
                    end else begin
                        // A is ignored while running; only idx drives the step
                        dcnt  <= '0;
                        idx   <= idx_nxt;
                        y_raw <= onehot_nxt;
                        wrap  <= (idx == {N{1'b1}});
                    end
                end
                default: begin
                    y_raw <= '0;
                end
            endcase
        end
    end

    assign Y = (ACTIVE_LOW != 0) ? ~y_raw : y_raw;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Scoreboard bench: two builds (default, and DWELL=1/ACTIVE_LOW=1) share stimulus.
module tb_decoder_nto2n_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] a = 3'd0;
    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_nto2n_scan dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(a),
        .Y(y0), .idx(idx0), .wrap(wrap0)
    );

    decoder_nto2n_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(a),
        .Y(y1), .idx(idx1), .wrap(wrap1)
    );

    // Model: scan position is start + (running edges since entry) / DWELL
    typedef struct {
        bit act;
        int start;
        int k;
        int idx;
        int y;
        bit wrap;
    } mst_t;

    typedef struct {
        int y0; int idx0; int w0;
        int y1; int idx1; int w1;
    } exp_t;

    mst_t st0, st1;
    exp_t q[$];

    function automatic mst_t reset_st();
        mst_t s;
        s.act = 0; s.start = 0; s.k = 0; s.idx = 0; s.y = 0; s.wrap = 0;
        return s;
    endfunction

    function automatic mst_t step(mst_t s, bit r, bit e, int m, int av, int dw);
        mst_t n = s;
        if (r) return reset_st();
        n.wrap = 0;
        if (!e) return n;
        case (m)
            0: begin n.act = 0; n.k = 0; n.idx = av; n.y = 1 << av; end
            1: begin n.act = 0; n.k = 0; n.idx = av; n.y = (1 << (av + 1)) - 1; end
            3: begin n.act = 0; n.k = 0; n.y = 0; end
            default: begin
                if (!s.act) begin
                    n.act = 1; n.start = av; n.k = 0; n.idx = av; n.y = 1 << av;
                end else begin
                    n.k    = s.k + 1;
                    n.idx  = (s.start + n.k / dw) % 8;
                    n.y    = 1 << n.idx;
                    n.wrap = (n.k % dw == 0) && (n.idx == 0);
                end
            end
        endcase
        return n;
    endfunction

    function automatic exp_t mk_exp();
        exp_t e;
        e.y0 = st0.y & 8'hFF;  e.idx0 = st0.idx; e.w0 = st0.wrap;
        e.y1 = ~st1.y & 8'hFF; e.idx1 = st1.idx; e.w1 = st1.wrap;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        st0 = step(st0, rst, en, int'(mode), int'(a), 4);
        st1 = step(st1, rst, en, int'(mode), int'(a), 1);
        q.push_back(mk_exp());
    endtask

    task automatic cyc(input bit r, input bit e, input int m, input int av);
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = 2'(m);
        a    = 3'(av);
        model_edge();
    endtask

    // Reset pulse between edges; the pending expectation is recomputed from reset
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y0", int'(y0), 8'h00);
        chk("async_rst_y1", int'(y1), 8'hFF);
        chk("async_rst_idx0", int'(idx0), 0);
        chk("async_rst_wrap0", int'(wrap0), 0);
        #1 rst = 1'b0;
        void'(q.pop_back());
        st0 = reset_st();
        st1 = reset_st();
        model_edge();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y0", int'(y0), e.y0);
                chk("idx0", int'(idx0), e.idx0);
                chk("wrap0", int'(wrap0), e.w0);
                chk("y1", int'(y1), e.y1);
                chk("idx1", int'(idx1), e.idx1);
                chk("wrap1", int'(wrap1), e.w1);
            end
        end
    end

    initial begin : driver
        st0 = reset_st();
        st1 = reset_st();
        #1;
        chk("reset_y0", int'(y0), 8'h00);
        chk("reset_y1", int'(y1), 8'hFF);
        chk("reset_idx0", int'(idx0), 0);
        chk("reset_wrap0", int'(wrap0), 0);
        cyc(1, 1, 0, 5);
        // Released but disabled: reset values must persist
        cyc(0, 0, 0, 5);
        cyc(0, 0, 2, 5);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, i);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 3);
        cyc(0, 1, 1, 7);
        cyc(0, 1, 3, 1);
        cyc(0, 1, 3, 6);
        // Scan from 6 with A changed mid-run, through wrap-around
        cyc(0, 1, 2, 6);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2, 6);
        for (int i = 0; i < 10; i++) cyc(0, 1, 2, 2);
        // Re-entry reloads from A, then freeze with dwell count 2
        cyc(0, 1, 0, 1);
        cyc(0, 1, 2, 4);
        cyc(0, 1, 2, 4);
        cyc(0, 1, 2, 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2, i % 8);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 2, 0);
        // Abort a running scan asynchronously, then re-enter at A=3
        cyc(0, 1, 2, 5);
        pulse_rst();
        cyc(0, 1, 2, 3);
        for (int i = 0; i < 6; i++) cyc(0, 1, 2, 0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 3, $urandom_range(0, 99) < 80,
                (r < 50) ? 2 : int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end
        cyc(0, 1, 2, 7);
        for (int i = 0; i < 40; i++) cyc(0, 1, 2, 0);
        begin
            int n = 0;
            while (q.size() != 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
            #2;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
